// File: rtl/button_debounce.sv
// Debounces a raw asynchronous button level: two-flop synchronizer, then a
// stability-qualifying FSM. Optional release pulse: define DEBOUNCE_RELEASE_PULSE_EN.
module button_debounce #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_in,
  output logic o_sig_out,
  output logic o_busy,
  output logic o_rel_pulse
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync0;
  logic             r_sync1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sigOut;
  logic             r_busy;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_nextSigOut;
  logic             w_nextBusy;

  // Only r_sync1 is allowed to feed the FSM; i_btn_in is metastability-prone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn_in;
      r_sync1 <= r_sync0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE_LOW;
      r_cnt    <= '0;
      r_sigOut <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_sigOut <= w_nextSigOut;
      r_busy   <= w_nextBusy;
    end
  end

  // Any reversion to the committed level drops the count back to zero.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = '0;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync1) begin
          w_nextState = WAIT_HIGH;
          w_nextCnt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!r_sync1) begin
          w_nextState = IDLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = IDLE_HIGH;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!r_sync1) begin
          w_nextState = WAIT_LOW;
          w_nextCnt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (r_sync1) begin
          w_nextState = IDLE_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = IDLE_LOW;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = IDLE_LOW;
      end
    endcase
    w_nextSigOut = (w_nextState == IDLE_HIGH) || (w_nextState == WAIT_LOW);
    w_nextBusy   = (w_nextState == WAIT_HIGH) || (w_nextState == WAIT_LOW);
  end

  assign o_sig_out = r_sigOut;
  assign o_busy    = r_busy;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic r_relPulse;
  logic w_commitLow;

  // Registered alongside r_sigOut so the pulse lines up with its falling edge.
  assign w_commitLow = (r_state == WAIT_LOW) && !r_sync1 && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_relPulse <= 1'b0;
    end else begin
      r_relPulse <= w_commitLow;
    end
  end

  assign o_rel_pulse = r_relPulse;
`else
  assign o_rel_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios then random
// bouncy input, all checked every cycle against a run-length reference model.
module tb_button_debounce;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 3;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam bit RelEnabled = 1'b1;
`else
  localparam bit RelEnabled = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_btn_in = 1'b0;
  logic o_sig_out;
  logic o_busy;
  logic o_rel_pulse;

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model: 2-deep delay line, committed level, and the length of
  // the current run of samples that disagree with the committed level.
  bit mS0, mS1, mLevel, mRel;
  int mRun;

  // Per-scenario observation helpers
  int edgeIdx, riseEdge, fallEdge, relCount, busyCount;
  bit sawHigh;

  button_debounce #(.CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_btn_in   (i_btn_in),
    .o_sig_out  (o_sig_out),
    .o_busy     (o_busy),
    .o_rel_pulse(o_rel_pulse)
  );

  always #5 i_clk = ~i_clk;

  task automatic modelEdge(input bit rst, input bit btn);
    if (rst) begin
      mS0 = 0; mS1 = 0; mLevel = 0; mRun = 0; mRel = 0;
    end else begin
      mRel = 0;
      if (mS1 != mLevel) begin
        mRun++;
        if (mRun == STABLE_CNT) begin
          mLevel = ~mLevel;
          mRun = 0;
          mRel = RelEnabled && (mLevel == 1'b0);
        end
      end else begin
        mRun = 0;
      end
      mS1 = mS0;
      mS0 = btn;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare just after.
  task automatic applyStimulus(input bit rst, input bit btn);
    @(negedge i_clk);
    i_rst    = rst;
    i_btn_in = btn;
    @(posedge i_clk);
    modelEdge(rst, btn);
    #1;
    edgeIdx++;
    checkOutput("sig_out", {31'b0, o_sig_out}, {31'b0, mLevel});
    checkOutput("busy", {31'b0, o_busy}, {31'b0, (mRun > 0)});
    checkOutput("rel_pulse", {31'b0, o_rel_pulse}, {31'b0, mRel});
    if (o_sig_out === 1'b1 && riseEdge == 0) riseEdge = edgeIdx;
    if (o_sig_out === 1'b0 && fallEdge == 0) fallEdge = edgeIdx;
    if (o_sig_out === 1'b1) sawHigh = 1;
    if (o_rel_pulse === 1'b1) relCount++;
    if (o_busy === 1'b1) busyCount++;
  endtask

  task automatic startScenario();
    edgeIdx = 0; riseEdge = 0; fallEdge = 0; relCount = 0; busyCount = 0; sawHigh = 0;
  endtask

  initial begin
    bit lvl;
    int runLen;
    bit bouncePat [7] = '{1, 1, 0, 1, 1, 1, 1};

    // Reset held with button pressed, then the held button qualifies anew
    startScenario();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1);
    startScenario();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1);
    checkOutput("post_reset_rise_edge", riseEdge, 6);

    // Release from IDLE_HIGH
    startScenario();
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);
    checkOutput("release_fall_edge", fallEdge, 6);
    checkOutput("release_pulse_count", relCount, RelEnabled ? 1 : 0);

    // Clean press
    startScenario();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1);
    checkOutput("press_rise_edge", riseEdge, 6);
    checkOutput("press_busy_cycles", busyCount, 3);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);

    // Glitch of STABLE_CNT-1 samples is rejected
    startScenario();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0);
    checkOutput("glitch_sig_high", {31'b0, sawHigh}, 0);
    checkOutput("glitch_busy_cycles", busyCount, 3);

    // Bounce restarts qualification
    startScenario();
    for (int i = 0; i < 7; i++) applyStimulus(0, bouncePat[i]);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1);
    checkOutput("bounce_rise_edge", riseEdge, 9);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);

    // Reset when count has reached 2, button still held
    startScenario();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkOutput("midqual_reset_busy", {31'b0, o_busy}, 0);
    checkOutput("midqual_reset_sig", {31'b0, o_sig_out}, 0);
    startScenario();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1);
    checkOutput("midqual_requalify_edge", riseEdge, 6);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);

    // Random bouncy input with occasional resets
    for (int blk = 0; blk < 300; blk++) begin
      lvl    = 1'($urandom_range(0, 1));
      runLen = $urandom_range(1, 7);
      for (int i = 0; i < runLen; i++)
        applyStimulus(($urandom_range(0, 63) == 0), lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions a raw asynchronous push-button/switch input into a clean, synchronous, glitch-free level.
- Its output drives the sig_in input of the downstream rising-edge trigger stage.
- Structure: two-flop synchronizer, then a stability counter with a 4-state FSM.
- The output level changes only after the synchronized input holds its new value for STABLE_CNT consecutive clocks.

Parameters:
- CNT_W, 16, width of the stability counter; must satisfy 2^CNT_W > STABLE_CNT-1.
- STABLE_CNT, 50000, consecutive stable samples required to commit a new level; legal range 2..2^CNT_W. 50000 equals 1 ms at 50 MHz.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw, asynchronous, bouncy button/switch level.
- sig_out  output  1  debounced level; feeds trigger.sig_in.
- busy  output  1  high while a candidate transition is being qualified.
- rel_pulse  output  1  one-cycle release pulse; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. It is sampled only on the clk rising edge and overrides all other logic.
- Reset values: sync0=0, sync1=0, state=IDLE_LOW, cnt=0, sig_out=0, busy=0, rel_pulse=0.
- Synchronizer: sync0 <= btn_in; sync1 <= sync0. Only sync1 feeds the FSM. btn_in never reaches any other logic.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - sig_out=1 in IDLE_HIGH and WAIT_LOW, 0 otherwise.
  - busy=1 in WAIT_HIGH and WAIT_LOW.
  - sig_out and busy are registered, never combinational from sync1.
- IDLE_LOW: if sync1=1, go to WAIT_HIGH with cnt<=1. Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - sync1=0: go to IDLE_LOW, cnt<=0 (glitch rejected).
  - sync1=1 and cnt=STABLE_CNT-1: go to IDLE_HIGH, cnt<=0, sig_out<=1.
  - Otherwise: cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW: mirror of the above with polarity inverted. The commit from WAIT_LOW goes to IDLE_LOW with sig_out<=0.
- Latency: btn_in is stable before rising edge E0. sig_out changes after edge E(STABLE_CNT+1): 2 synchronizer edges plus STABLE_CNT qualifying samples.
- Minimum accepted pulse: exactly STABLE_CNT consecutive sync1 samples. STABLE_CNT-1 samples followed by reversion gives no output change.
- Counter arithmetic: unsigned CNT_W bits. The counter never exceeds STABLE_CNT-1 and never wraps.
- Bounce during qualification: any reversion restarts qualification from zero. Partial counts do not accumulate across bounces.
- Reset mid-qualification: returns to IDLE_LOW, sig_out=0 on the next edge. This holds even if the button is still held. A held button then re-qualifies as a new press after reset release.
- Output guarantee: sig_out never toggles more than once per STABLE_CNT cycles, so the downstream trigger emits at most one pulse per qualified press.

Optional Feature:
- Macro: DEBOUNCE_RELEASE_PULSE_EN.
- Defined: rel_pulse=1 for exactly one clock, on the cycle after the WAIT_LOW→IDLE_LOW commit, aligned with sig_out falling. Registered; reset value 0.
- Undefined: rel_pulse is tied to constant 0 and no extra flops are built.
- All other behaviour is identical in both builds.

Test Plan (bench overrides STABLE_CNT=4, CNT_W=3):
- Reset: hold rst=1 for 3 clocks with btn_in=1 → sig_out=0, busy=0, rel_pulse=0 throughout. After release, sig_out=1 on edge 6 counted from the first post-reset edge.
- Clean press: btn_in 0→1 before E0, then held → busy=1 after E2. sig_out=1 after E5 (6th edge). busy=0 after E5.
- Glitch reject: btn_in high for exactly 3 clocks, then low → sig_out stays 0. busy pulses high for 3 cycles, then returns to 0.
- Bounce: pattern 1,1,0,1,1,1,1 held → count restarts at the 0. sig_out rises 4 qualifying samples after the last 0 reaches sync1.
- Release with DEBOUNCE_RELEASE_PULSE_EN: from IDLE_HIGH, btn_in→0 → sig_out falls after the 6th edge. rel_pulse=1 for exactly 1 cycle. Without the macro, rel_pulse is always 0.
- Reset mid-qualification: assert rst when cnt=2 in WAIT_HIGH → next edge state=IDLE_LOW, cnt=0, busy=0, sig_out=0.
